// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI slave front end.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int DEF_FRAME_W = 10;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_serializer
// Description : Load-and-shift register that drives read data MSB-first on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_serializer import spi_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o
);

    localparam int BCNT_W = $clog2(DATA_W + 1);

    // The MSB leaves on the load edge, so only the remaining bits are held.
    logic [DATA_W-2:0] sh_q, sh_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic              miso_q, miso_d;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        miso_d = 1'b0;
        if (clear_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sh_d   = data_i[DATA_W-2:0];
            cnt_d  = BCNT_W'(DATA_W - 1);
            miso_d = data_i[DATA_W-1];
        end else if (cnt_q != '0) begin
            miso_d = sh_q[DATA_W-2];
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q - BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            miso_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            miso_q <= miso_d;
        end
    end

    assign miso_o = miso_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_fsm
// Description : SPI slave FSM: deserialises command frames for the RAM and
//               returns read data on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_fsm import spi_pkg::*; #(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int              CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-2:0] shift_q;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               rd_addr_held_q;
    logic               tx_done_q;

    logic [FRAME_W-1:0] frame_d;
    logic [1:0]         cmd_d;
    logic               tx_load;
    logic               tx_clear;

    assign frame_d = {shift_q, MOSI};
    assign cmd_d   = frame_d[FRAME_W-1 -: 2];

    // One read-data response per frame, accepted only once the frame strobe is gone.
    assign tx_load  = (state_q == READ_DATA) && (cnt_q == CNT_FULL) && !rx_valid_q
                      && !tx_done_q && tx_valid && !SS_n;
    assign tx_clear = SS_n && (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_held_q <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (tx_clear) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                tx_done_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!SS_n) begin
                            state_q <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        shift_q   <= {{(FRAME_W-2){1'b0}}, MOSI};
                        cnt_q     <= CNT_W'(1);
                        tx_done_q <= 1'b0;
                        if (!MOSI) begin
                            state_q <= WRITE;
                        end else if (rd_addr_held_q) begin
                            state_q <= READ_DATA;
                        end else begin
                            state_q <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        // Counter saturates at a full frame; later bits are dropped.
                        if (cnt_q < CNT_FULL) begin
                            shift_q <= frame_d[FRAME_W-2:0];
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_LAST) begin
                                rx_data_q  <= frame_d;
                                rx_valid_q <= 1'b1;
                                if (cmd_d == CMD_RD_ADDR) begin
                                    rd_addr_held_q <= 1'b1;
                                end else if (cmd_d == CMD_RD_DATA) begin
                                    rd_addr_held_q <= 1'b0;
                                end
                            end
                        end
                        if (tx_load) begin
                            tx_done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx_serializer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tx_load),
        .clear_i (tx_clear),
        .data_i  (tx_data),
        .miso_o  (MISO)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_fsm
// Description : Scoreboard bench for spi_slave_fsm with a small RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_fsm;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       ram_tv;
    logic       stray_tv;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_rx_q[$];
    logic       exp_miso_q[$];
    bit         miso_go   = 1'b0;
    bit         exp_serve = 1'b0;
    logic [7:0] ram_rd    = 8'h00;

    always #5 clk = ~clk;

    assign tx_valid = ram_tv | stray_tv;

    spi_slave_fsm #(
        .FRAME_W (10),
        .DATA_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents data.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_valid unexpected: got rx_data %0h expected no strobe at %0t", rx_data, $time);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
                end
            end
            if (miso_go && exp_miso_q.size() > 0) begin
                check("MISO bit", 32'(MISO), 32'(exp_miso_q.pop_front()));
                if (exp_miso_q.size() == 0) miso_go = 1'b0;
            end else begin
                check("MISO idle", 32'(MISO), 32'd0);
            end
            if (tx_valid && exp_miso_q.size() > 0) miso_go = 1'b1;
        end
    end

    // RAM model: answers every read-data word one cycle after its strobe.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_data[9:8] == 2'b11) begin
            if (exp_serve) begin
                for (int i = 7; i >= 0; i--) exp_miso_q.push_back(ram_rd[i]);
            end
            @(posedge clk);
            #1;
            ram_tv  = 1'b1;
            tx_data = ram_rd;
            @(posedge clk);
            #1;
            ram_tv  = 1'b0;
        end
    end

    task automatic send_frame(input logic [9:0] f, input int nbits, input state_e exp_st, input int hold);
        SS_n = 1'b0;
        @(posedge clk);
        #1;
        if (nbits == 10) exp_rx_q.push_back(f);
        for (int i = 0; i < nbits; i++) begin
            MOSI = f[9-i];
            @(posedge clk);
            #1;
            if (i == 0) check("state after cmd bit", 32'(dut.state_q), 32'(exp_st));
        end
        for (int i = 0; i < hold; i++) begin
            MOSI = ~MOSI;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_ss();
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(posedge clk);
        #1;
        check("state after SS_n high", 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        ram_tv   = 1'b0;
        stray_tv = 1'b0;
        tx_data  = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        check("reset MISO", 32'(MISO), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset state", 32'(dut.state_q), 32'(IDLE));
        check("reset rd_addr_held", 32'(dut.rd_addr_held_q), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write address, extra bits afterwards must not re-strobe.
        send_frame(10'b00_0000_0101, 10, WRITE, 4);
        release_ss();

        // Write data, with a stray tx_valid that must be ignored.
        send_frame(10'b01_1010_1010, 10, WRITE, 0);
        stray_tv = 1'b1;
        @(posedge clk);
        #1;
        stray_tv = 1'b0;
        @(posedge clk);
        #1;
        check("rd_addr_held after writes", 32'(dut.rd_addr_held_q), 32'd0);
        release_ss();

        // Read address then read data.
        send_frame(10'b10_0000_0101, 10, READ_ADD, 1);
        check("rd_addr_held after read addr", 32'(dut.rd_addr_held_q), 32'd1);
        release_ss();
        ram_rd    = 8'hA5;
        exp_serve = 1'b1;
        send_frame(10'b11_0011_0011, 10, READ_DATA, 12);
        check("state holds READ_DATA", 32'(dut.state_q), 32'(READ_DATA));
        check("rd_addr_held after read data", 32'(dut.rd_addr_held_q), 32'd0);
        check("MISO bits all seen", 32'(exp_miso_q.size()), 32'd0);
        release_ss();
        exp_serve = 1'b0;

        // Abort after 5 bits, then a full frame.
        send_frame(10'b01_1111_0000, 5, WRITE, 0);
        release_ss();
        send_frame(10'b01_0011_1100, 10, WRITE, 0);
        release_ss();

        // Reset in the middle of the MISO phase.
        send_frame(10'b10_0000_1000, 10, READ_ADD, 0);
        release_ss();
        ram_rd    = 8'hE7;
        exp_serve = 1'b1;
        send_frame(10'b11_0000_1000, 10, READ_DATA, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_miso_q.delete();
        miso_go   = 1'b0;
        exp_serve = 1'b0;
        #1;
        check("async reset MISO", 32'(MISO), 32'd0);
        check("async reset rx_valid", 32'(rx_valid), 32'd0);
        check("async reset rx_data", 32'(rx_data), 32'd0);
        check("async reset state", 32'(dut.state_q), 32'(IDLE));
        check("async reset rd_addr_held", 32'(dut.rd_addr_held_q), 32'd0);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(10'b11_0000_0001, 10, READ_ADD, 3);
        check("rd_addr_held after 11 in READ_ADD", 32'(dut.rd_addr_held_q), 32'd0);
        release_ss();

        repeat (3) @(posedge clk);
        #1;
        check("rx scoreboard drained", 32'(exp_rx_q.size()), 32'd0);
        check("miso scoreboard drained", 32'(exp_miso_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
